// File: rtl/axis2axi4_wr.sv
// rtl/axis2axi4_wr.sv - AXI-Stream to AXI4 burst write bridge (optional TLAST checker: AXIS2AXI4_WR_TLAST_CHK_EN)
module axis2axi4_wr #(
    parameter int ID_W      = 1,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int LEN_W     = 16,
    parameter int BURST_MAX = 16
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                start,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [LEN_W-1:0]    len,
    output logic                busy,
    output logic                done,
    output logic                err,
`ifdef AXIS2AXI4_WR_TLAST_CHK_EN
    output logic                tlast_err,
`endif
    input  logic                s_TVALID,
    output logic                s_TREADY,
    input  logic [DATA_W-1:0]   s_TDATA,
    input  logic [DATA_W/8-1:0] s_TKEEP,
    input  logic                s_TLAST,
    output logic [ID_W-1:0]     AWID,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [7:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWLOCK,
    output logic [3:0]          AWCACHE,
    output logic [2:0]          AWPROT,
    output logic [3:0]          AWQOS,
    output logic [3:0]          AWREGION,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [ID_W-1:0]     BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY
);

    localparam int BYTES = DATA_W / 8;
    localparam int SIZE  = $clog2(BYTES);
    // Wide enough for the remaining-beat count and for 4096 beats (byte-wide bus).
    localparam int CW    = (LEN_W > 14) ? LEN_W : 14;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic [8:0]        beat_cnt_q;
    logic              awvalid_q;
    logic              bready_q;
    logic              done_q;
    logic              err_q;
`ifdef AXIS2AXI4_WR_TLAST_CHK_EN
    logic              tlast_err_q;
`endif

    logic [12:0]       page_bytes;
    logic [CW-1:0]     page_beats;
    logic [CW-1:0]     rem_ext;
    logic [8:0]        burst_beats;
    logic [ADDR_W-1:0] cur_addr_d;
    logic [LEN_W-1:0]  rem_d;
    logic              in_data;
    logic              w_fire;

    // Bytes left before the next 4 KB boundary; never zero, at most 4096.
    assign page_bytes = 13'd4096 - {1'b0, cur_addr_q[11:0]};
    assign page_beats = CW'(page_bytes >> SIZE);
    assign rem_ext    = CW'(rem_q);

    // Burst size is the smallest of the configured cap, the 4 KB page room and the beats left.
    always_comb begin
        burst_beats = 9'(BURST_MAX);
        if (page_beats < CW'(burst_beats)) begin
            burst_beats = page_beats[8:0];
        end
        if (rem_ext < CW'(burst_beats)) begin
            burst_beats = rem_ext[8:0];
        end
    end

    // Address and remaining count as they become once the current AW is accepted.
    assign cur_addr_d = cur_addr_q + (ADDR_W'(burst_beats) << SIZE);
    assign rem_d      = rem_q - LEN_W'(burst_beats);

    assign in_data  = (state_q == DATA);
    assign WVALID   = in_data && s_TVALID;
    assign s_TREADY = in_data && WREADY;
    assign WDATA    = s_TDATA;
    assign WSTRB    = s_TKEEP;
    assign WLAST    = in_data && (beat_cnt_q == 9'd1);
    assign w_fire   = WVALID && WREADY;

    // AWADDR/AWLEN derive from registers that only move on the AW handshake, so they hold while stalled.
    assign AWID     = '0;
    assign AWADDR   = cur_addr_q;
    assign AWLEN    = 8'(burst_beats - 9'd1);
    assign AWSIZE   = 3'(SIZE);
    assign AWBURST  = 2'b01;
    assign AWLOCK   = 1'b0;
    assign AWCACHE  = 4'b0011;
    assign AWPROT   = 3'b000;
    assign AWQOS    = 4'b0000;
    assign AWREGION = 4'b0000;
    assign AWVALID  = awvalid_q;
    assign BREADY   = bready_q;

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign err  = err_q;
`ifdef AXIS2AXI4_WR_TLAST_CHK_EN
    assign tlast_err = tlast_err_q;
`endif

    // Main control FSM: one burst at a time, address phase, data phase, then wait for its response.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            rem_q       <= '0;
            beat_cnt_q  <= '0;
            awvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef AXIS2AXI4_WR_TLAST_CHK_EN
            tlast_err_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_q       <= 1'b0;
`ifdef AXIS2AXI4_WR_TLAST_CHK_EN
                        tlast_err_q <= 1'b0;
`endif
                        if (len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            cur_addr_q <= addr;
                            rem_q      <= len;
                            awvalid_q  <= 1'b1;
                            state_q    <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (awvalid_q && AWREADY) begin
                        awvalid_q  <= 1'b0;
                        cur_addr_q <= cur_addr_d;
                        rem_q      <= rem_d;
                        beat_cnt_q <= burst_beats;
                        state_q    <= DATA;
                    end
                end
                DATA: begin
                    if (w_fire) begin
                        beat_cnt_q <= beat_cnt_q - 9'd1;
`ifdef AXIS2AXI4_WR_TLAST_CHK_EN
                        // Final beat of the whole transfer is the last beat of the burst with nothing left.
                        if (s_TLAST != (WLAST && (rem_q == '0))) begin
                            tlast_err_q <= 1'b1;
                        end
`endif
                        if (WLAST) begin
                            bready_q <= 1'b1;
                            state_q  <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (BVALID && bready_q) begin
                        bready_q <= 1'b0;
                        if (BRESP != 2'b00) begin
                            err_q <= 1'b1;
                        end
                        if (rem_q == '0) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            awvalid_q <= 1'b1;
                            state_q   <= ADDR;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, BID
`ifndef AXIS2AXI4_WR_TLAST_CHK_EN
                         , s_TLAST
`endif
                         };

endmodule
